// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache memory access path.
//   state_e          : access sequencer mode (CLEAR sweep / RUN service)
//   RAM_READ_LATENCY : cycles from RAM port sample to valid dout
//   RSP_LATENCY      : cycles from request acceptance to rsp_rdata capture
package cache_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int unsigned RAM_READ_LATENCY = 1;
  localparam int unsigned RSP_LATENCY      = RAM_READ_LATENCY + 1;

endpackage

// File: rtl/ram_access_sequencer.sv
// Initiator for a single-port, read-first RAM with a 1-cycle registered dout.
// Accepts valid/ready client requests, drives the registered RAM port and
// returns the pre-access word of every request with a fixed 2-cycle latency.
// After reset, or on clear_start, it sweeps CLEAR_VALUE into every location.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready is combinational)
//   req_we/req_addr/req_wdata     request: write enable, address, write data
//   rsp_valid/rsp_rdata           one-cycle response pulse, read-first data
//   clear_start/clear_busy        start clear sweep / sweep in progress
//   ram_addr/ram_we/ram_din       registered RAM port outputs
//   ram_dout                      RAM read data
module ram_access_sequencer
  import cache_mem_pkg::*;
#(
  parameter int unsigned          SIZE          = 4096,
  parameter int unsigned          ADDRESS_SPACE = 12,
  parameter int unsigned          DATA_SIZE     = 32,
  parameter logic [DATA_SIZE-1:0] CLEAR_VALUE   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_SPACE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0]     req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_SIZE-1:0]     rsp_rdata,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic [ADDRESS_SPACE-1:0] ram_addr,
  output logic                     ram_we,
  output logic [DATA_SIZE-1:0]     ram_din,
  input  logic [DATA_SIZE-1:0]     ram_dout
);

  localparam logic [ADDRESS_SPACE-1:0] LastAddr = ADDRESS_SPACE'(SIZE - 1);

  state_e                   state_q, state_d;
  logic [ADDRESS_SPACE-1:0] cnt_q, cnt_d;
  logic [ADDRESS_SPACE-1:0] ram_addr_q, ram_addr_d;
  logic                     ram_we_q, ram_we_d;
  logic [DATA_SIZE-1:0]     ram_din_q, ram_din_d;
  logic [RSP_LATENCY-1:0]   pipe_q, pipe_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DATA_SIZE-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                     accept;

  // clear_start takes priority over any request presented in the same cycle.
  assign req_ready  = (state_q == RUN) && !clear_start;
  assign clear_busy = (state_q == CLEAR);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      CLEAR: begin
        ram_we_d   = 1'b1;
        ram_addr_d = cnt_q;
        ram_din_d  = CLEAR_VALUE;
        if (cnt_q == LastAddr) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (req_valid) begin
          accept     = 1'b1;
          ram_we_d   = req_we;
          ram_addr_d = req_addr;
          if (req_we) begin
            ram_din_d = req_wdata;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // In-flight tracking: pipe_q[0] marks a request on the RAM port, the last
  // stage marks valid ram_dout; sweep writes never enter the pipe.
  always_comb begin
    pipe_d      = {pipe_q[RSP_LATENCY-2:0], accept};
    rsp_valid_d = pipe_q[RSP_LATENCY-1];
    rsp_rdata_d = pipe_q[RSP_LATENCY-1] ? ram_dout : rsp_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      pipe_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
      pipe_q      <= pipe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_din   = ram_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
